// File: rtl/cpu_pkg.sv
// Shared definitions for the 2-bit CPU and its program loader.
// Instruction width, address width, opcode constants and loader state encoding.
package cpu_pkg;

    localparam int unsigned ADDR_WIDTH  = 2;
    localparam int unsigned INSTR_WIDTH = 2;
    localparam int unsigned DEPTH       = 1 << ADDR_WIDTH;

    // Instruction word is {opcode, data}
    localparam logic OPC_LOAD = 1'b0;
    localparam logic OPC_ADD  = 1'b1;

    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    // CHECK and ERROR are only reachable with PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_e;

endpackage

// File: rtl/instr_ram.sv
// Instruction RAM: synchronous write from the loader, asynchronous read for CPU fetch.
module instr_ram
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   wr_en_i,
    input  logic [ADDR_WIDTH-1:0]  wr_addr_i,
    input  logic [INSTR_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0]  rd_addr_i,
    output logic [INSTR_WIDTH-1:0] rd_data_o
);

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents survive reset so a partial load leaves old words in place
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/program_loader.sv
// Program loader: streams host words into the instruction RAM, holds the CPU in reset
// while loading and releases it afterwards.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (trailing checksum word after DEPTH words).
module program_loader
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [INSTR_WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   cpu_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic [INSTR_WIDTH-1:0] fetch_instr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    loader_state_e          state_q;
    logic [ADDR_WIDTH-1:0]  cnt_q;
    logic [ADDR_WIDTH-1:0]  cnt_d;
    logic                   wr_en_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [INSTR_WIDTH-1:0] wr_data_q;
    logic                   cpu_reset_q;
    logic                   done_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [INSTR_WIDTH-1:0] sum_q;
    logic [INSTR_WIDTH-1:0] sum_d;
    logic                   err_q;

    assign sum_d = INSTR_WIDTH'(sum_q + in_data);
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

    assign cnt_d = ADDR_WIDTH'(cnt_q + 1'b1);

    // Handshake and status decode straight from the state register
    assign in_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign busy     = (state_q == ST_LOAD) || (state_q == ST_CHECK) || (state_q == ST_DRAIN);

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;

    // Loader FSM with counter, checksum and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_q;
                        wr_data_q <= in_data;
                        cnt_q     <= cnt_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum_q     <= sum_d;
                        if (cnt_q == LAST_ADDR) begin
                            state_q <= ST_CHECK;
                        end
`else
                        if (cnt_q == LAST_ADDR) begin
                            state_q <= ST_DRAIN;
                        end
`endif
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    // Checksum word is compared only, never written to RAM
                    if (in_valid) begin
                        if (in_data == sum_q) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_ERROR: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
`endif
                ST_DRAIN: begin
                    // Final write retires this cycle; release the CPU next
                    state_q     <= ST_RUN;
                    cpu_reset_q <= 1'b0;
                    done_q      <= 1'b1;
                end
                ST_RUN: begin
                    if (start) begin
                        state_q     <= ST_LOAD;
                        cpu_reset_q <= 1'b1;
                        cnt_q       <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum_q       <= '0;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    instr_ram u_instr_ram (
        .clk       (clk),
        .wr_en_i   (wr_en_q),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (wr_data_q),
        .rd_addr_i (fetch_addr),
        .rd_data_o (fetch_instr)
    );

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected RAM writes, a negedge
// monitor pops and compares them whenever wr_en is seen.
module tb_program_loader;

    typedef struct packed {
        logic [1:0] addr;
        logic [1:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [1:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [1:0] wr_data;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] fetch_addr;
    logic [1:0] fetch_instr;

    wr_t        exp_q[$];
    logic [1:0] ram_model [4];
    logic [1:0] exp_addr;
    int         n_pass  = 0;
    int         n_total = 0;

    program_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every RAM write must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr_en", 32'(wr_en), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = 2'd0;
    endtask

    // One transferred word; push=1 means it must appear as a RAM write
    task automatic xfer(input logic [1:0] d, input bit push);
        wr_t e;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            e.addr = exp_addr;
            e.data = d;
            exp_q.push_back(e);
            ram_model[exp_addr] = d;
            exp_addr = exp_addr + 2'd1;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    // prog[7:6] is the first word; checksum word appended when the feature is built in
    task automatic load_prog(input logic [7:0] prog, input bit toggle, input logic [1:0] cks_xor);
        logic [1:0] sum;
        logic [1:0] w;
        sum = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w = prog[7-2*i -: 2];
            sum = sum + w;
            xfer(w, 1'b1);
            if (toggle && i < 3) idle_cycle();
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (toggle) idle_cycle();
        xfer(sum ^ cks_xor, 1'b0);
`else
        if (cks_xor != 2'd0) sum = 2'd0;
`endif
    endtask

    // Called in the DRAIN cycle right after the final transfer
    task automatic finish_load(input string tag);
        check({tag, "_drain_busy"},      32'(busy),      32'd1);
        check({tag, "_drain_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_drain_done"},      32'(done),      32'd0);
        check({tag, "_drain_in_ready"},  32'(in_ready),  32'd0);
        idle_cycle();
        check({tag, "_run_done"},        32'(done),      32'd1);
        check({tag, "_run_cpu_reset"},   32'(cpu_reset), 32'd0);
        check({tag, "_run_busy"},        32'(busy),      32'd0);
        idle_cycle();
        check({tag, "_done_pulse_end"},  32'(done),      32'd0);
        check({tag, "_run_cpu_reset2"},  32'(cpu_reset), 32'd0);
        check({tag, "_writes_retired"},  32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < 4; i++) begin
            fetch_addr = 2'(i);
            #1;
            check({tag, "_ram"}, 32'(fetch_instr), 32'(ram_model[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outputs"},
              32'({in_ready, wr_en, wr_addr, wr_data, cpu_reset, busy, done, err}),
              32'(10'b0_0_00_00_1_0_0_0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 2'd0;
        fetch_addr = 2'd0; exp_addr = 2'd0;
        for (int i = 0; i < 4; i++) ram_model[i] = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        idle_cycle();

        // in_valid in IDLE must not be accepted
        in_valid = 1'b1; in_data = 2'b11;
        idle_cycle();
        check("idle_in_ready", 32'(in_ready), 32'd0);
        idle_cycle();
        check("idle_in_ready2", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Back-to-back stream 01,11,00,00
        pulse_start();
        check("load_in_ready",  32'(in_ready),  32'd1);
        check("load_busy",      32'(busy),      32'd1);
        check("load_cpu_reset", 32'(cpu_reset), 32'd1);
        load_prog(8'b01_11_00_00, 1'b0, 2'd0);
        finish_load("t1");
        check_ram("t1");

        // Reload from RUN with valid toggling
        pulse_start();
        check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        load_prog(8'b01_11_00_00, 1'b1, 2'd0);
        finish_load("t2");
        check_ram("t2");

        // Reload from RUN with 00,01,01,01
        pulse_start();
        check("t4_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t4_err",       32'(err),       32'd0);
        load_prog(8'b00_01_01_01, 1'b0, 2'd0);
        finish_load("t4");
        check_ram("t4");

        // Reset after two words: immediate return to reset values
        pulse_start();
        xfer(2'b10, 1'b1);
        xfer(2'b11, 1'b1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_reset_outputs("midload_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycle();

        // start with in_valid in IDLE takes no word; start held during LOAD is ignored
        start = 1'b1; in_valid = 1'b1; in_data = 2'b10;
        idle_cycle();
        in_valid = 1'b0;
        check("start_valid_in_ready", 32'(in_ready), 32'd1);
        check("start_valid_no_wr",    32'(wr_en),    32'd0);
        exp_addr = 2'd0;
        load_prog(8'b10_01_11_10, 1'b0, 2'd0);
        start = 1'b0;
        finish_load("t5");
        check_ram("t5");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Wrong checksum: ERROR, CPU stays held, done never pulses
        pulse_start();
        load_prog(8'b01_11_00_00, 1'b0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            check("cks_err",       32'(err),       32'd1);
            check("cks_cpu_reset", 32'(cpu_reset), 32'd1);
            check("cks_busy",      32'(busy),      32'd0);
            check("cks_done",      32'(done),      32'd0);
            idle_cycle();
        end
        check("cks_writes_retired", 32'(exp_q.size()), 32'd0);
        pulse_start();
        check("cks_err_cleared", 32'(err), 32'd0);
        check("cks_reload_ready", 32'(in_ready), 32'd1);
        load_prog(8'b01_11_00_00, 1'b0, 2'd0);
        finish_load("t6");
        check("t6_err", 32'(err), 32'd0);
        check_ram("t6");
`endif

        idle_cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
